// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity encoding and
// the default word/prescale widths used by both the transmitter and receiver.
package uart_pkg;

  localparam int unsigned DefaultDwidth = 8;
  localparam int unsigned DefaultPwidth = 6;

  // parity_type encoding
  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period counter plus data bit index for the UART transmitter.
// The counter runs 0..P-1 while enabled (prescale of 0 behaves as 1) and
// pulses bit_done on the last cycle of each bit period. The bit index steps on
// bit_done only while index counting is enabled, wrapping after DWIDTH-1.
module tx_baud_counter #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PWIDTH = 6,
  parameter int unsigned IWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_idx_en,
  input  logic [PWIDTH-1:0] i_prescale,
  output logic              o_bit_done,
  output logic [IWIDTH-1:0] o_bit_index
);

  localparam logic [IWIDTH-1:0] LastIdx = IWIDTH'(DWIDTH - 1);

  logic [PWIDTH-1:0] r_cnt;
  logic [IWIDTH-1:0] r_idx;
  logic [PWIDTH-1:0] w_cnt_max;
  logic              w_last;

  // Terminal count of the bit period; a zero prescale collapses to one cycle
  always_comb begin
    w_cnt_max = (i_prescale == '0) ? '0 : (i_prescale - PWIDTH'(1));
    w_last    = (r_cnt == w_cnt_max);
  end

  assign o_bit_done  = i_en & w_last;
  assign o_bit_index = r_idx;

  // Counter and index registers; both held at zero while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      if (i_idx_en) begin
        r_idx <= (r_idx == LastIdx) ? '0 : (r_idx + IWIDTH'(1));
      end
    end else begin
      r_cnt <= r_cnt + PWIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a parallel word in IDLE and shifts out
// start, DWIDTH data bits (LSB first), optional parity and one stop bit,
// each held for the latched prescale number of clk cycles.
// s_data and busy come straight from flops; their next values are decoded
// from the next state so the start bit appears one cycle after acceptance.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DWIDTH = DefaultDwidth,
  parameter int unsigned PWIDTH = DefaultPwidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] p_data,
  input  logic              data_valid,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic [PWIDTH-1:0] prescale,
  output logic              s_data,
  output logic              busy
);

  localparam int unsigned IWIDTH = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [IWIDTH-1:0] LastIdx = IWIDTH'(DWIDTH - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_next;
  logic [DWIDTH-1:0] r_data;
  logic              r_parity_en;
  logic              r_parity_type;
  logic [PWIDTH-1:0] r_prescale;
  logic              r_s_data;
  logic              r_busy;

  logic              w_accept;
  logic              w_cnt_en;
  logic              w_idx_en;
  logic              w_bit_done;
  logic [IWIDTH-1:0] w_bit_index;
  logic [IWIDTH-1:0] w_idx_next;
  logic              w_parity;
  logic              w_s_data_next;
  logic              w_busy_next;

  assign w_accept = (r_state == StIdle) && data_valid;
  assign w_cnt_en = (r_state != StIdle);
  assign w_idx_en = (r_state == StData);

  tx_baud_counter #(
    .DWIDTH (DWIDTH),
    .PWIDTH (PWIDTH),
    .IWIDTH (IWIDTH)
  ) u_baud (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_cnt_en),
    .i_idx_en    (w_idx_en),
    .i_prescale  (r_prescale),
    .o_bit_done  (w_bit_done),
    .o_bit_index (w_bit_index)
  );

  // Capture the word and its framing options at acceptance only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data        <= '0;
      r_parity_en   <= 1'b0;
      r_parity_type <= 1'b0;
      r_prescale    <= '0;
    end else if (w_accept) begin
      r_data        <= p_data;
      r_parity_en   <= parity_en;
      r_parity_type <= parity_type;
      r_prescale    <= prescale;
    end
  end

  // State register and registered line outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_s_data <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_s_data <= w_s_data_next;
      r_busy   <= w_busy_next;
    end
  end

  // Next-state logic; every non-idle state advances only on bit_done
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (data_valid) w_state_next = StStart;
      end
      StStart: begin
        if (w_bit_done) w_state_next = StData;
      end
      StData: begin
        if (w_bit_done && (w_bit_index == LastIdx)) begin
          w_state_next = r_parity_en ? StParity : StStop;
        end
      end
      StParity: begin
        if (w_bit_done) w_state_next = StStop;
      end
      StStop: begin
        if (w_bit_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Parity over the latched word; odd parity is the inverse of even
  always_comb begin
    w_parity = ^r_data;
    unique case (r_parity_type)
      ParityEven: w_parity = ^r_data;
      ParityOdd:  w_parity = ~^r_data;
    endcase
  end

  // Next line value: decode the bit that will be on the wire after this edge
  always_comb begin
    w_idx_next = w_bit_index;
    if ((r_state == StData) && w_bit_done) begin
      w_idx_next = w_bit_index + IWIDTH'(1);
    end
    w_s_data_next = 1'b1;
    case (w_state_next)
      StStart:  w_s_data_next = 1'b0;
      StData:   w_s_data_next = r_data[w_idx_next];
      StParity: w_s_data_next = w_parity;
      default:  w_s_data_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != StIdle);
  end

  assign s_data = r_s_data;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, parity, prescale edge cases,
// ignored mid-frame requests, back-to-back frames, async reset and a
// behavioural loopback receiver over random words.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_en;
  logic       parity_type;
  logic [5:0] prescale;
  logic       s_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic cap_s [0:511];
  logic cap_b [0:511];

  uart_tx #(
    .DWIDTH (8),
    .PWIDTH (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .prescale    (prescale),
    .s_data      (s_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

  // Present a word for one acceptance edge; returns at the sample point of cycle 0
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    @(negedge clk);
    p_data      = d;
    parity_en   = pe;
    parity_type = pt;
    prescale    = ps;
    data_valid  = 1'b1;
    @(negedge clk);
    data_valid  = 1'b0;
  endtask

  // Record n cycles of the line; optionally pulse a 0x3C request at cycle inj
  task automatic capture(input int n, input int inj);
    for (int c = 0; c < n; c++) begin
      cap_s[c] = s_data;
      cap_b[c] = busy;
      if (c == inj) begin
        data_valid  = 1'b1;
        p_data      = 8'h3C;
        parity_en   = 1'b0;
        parity_type = 1'b1;
        prescale    = 6'd3;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    data_valid  = 1'b1;
    p_data      = 8'h00;
    parity_en   = 1'b0;
    parity_type = 1'b0;
    prescale    = 6'd1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (s_data !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: s_data=%b busy=%b, expected 1 0", s_data, busy);
    end
    rst        = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s_data !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: s_data=%b busy=%b, expected 1 0", s_data, busy);
    end
  endtask

  task automatic test_parity_a5();
    logic [10:0] bits;
    logic        es;
    logic        eb;
    bits = 11'b10101001010;
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(90, -1);
    for (int c = 0; c < 90; c++) begin
      es = (c < 88) ? bits[c/8] : 1'b1;
      eb = (c < 88);
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL a5_even c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c], cap_b[c],
                 es, eb);
      end
    end
  endtask

  task automatic test_parity_01();
    logic ep;
    for (int pt = 0; pt < 2; pt++) begin
      ep = (pt == 1) ? 1'b0 : 1'b1;
      send(8'h01, 1'b1, pt[0], 6'd2);
      capture(24, -1);
      n_vec++;
      if (cap_s[18] !== ep || cap_s[19] !== ep) begin
        n_err++;
        $display("FAIL parity01 pt=%0d: bit=%b%b, expected %b%b", pt, cap_s[18], cap_s[19], ep, ep);
      end
      n_vec++;
      if (cap_s[20] !== 1'b1 || cap_b[21] !== 1'b1 || cap_b[22] !== 1'b0) begin
        n_err++;
        $display("FAIL parity01_len pt=%0d: stop=%b busy21=%b busy22=%b, expected 1 1 0", pt,
                 cap_s[20], cap_b[21], cap_b[22]);
      end
    end
  endtask

  task automatic test_no_parity_ff();
    logic [9:0] bits;
    logic       es;
    logic       eb;
    bits = 10'b1111111110;
    send(8'hFF, 1'b0, 1'b1, 6'd4);
    capture(42, -1);
    for (int c = 0; c < 42; c++) begin
      es = (c < 40) ? bits[c/4] : 1'b1;
      eb = (c < 40);
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL ff_nopar c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c], cap_b[c],
                 es, eb);
      end
    end
  endtask

  task automatic test_prescale_zero();
    logic [9:0] bits;
    logic       es;
    logic       eb;
    bits = 10'b1100101100;
    send(8'h96, 1'b0, 1'b0, 6'd0);
    capture(12, -1);
    for (int c = 0; c < 12; c++) begin
      es = (c < 10) ? bits[c] : 1'b1;
      eb = (c < 10);
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL ps0 c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c], cap_b[c], es, eb);
      end
    end
  endtask

  task automatic test_ignore_mid_frame();
    logic [10:0] a5;
    logic [9:0]  b3c;
    logic        es;
    logic        eb;
    a5  = 11'b10101001010;
    b3c = 10'b1001111000;
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(96, 30);
    for (int c = 0; c < 96; c++) begin
      es = (c < 88) ? a5[c/8] : 1'b1;
      eb = (c < 88);
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL ignore_a5 c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c], cap_b[c],
                 es, eb);
      end
    end
    send(8'h3C, 1'b0, 1'b0, 6'd8);
    capture(82, -1);
    for (int c = 0; c < 82; c++) begin
      es = (c < 80) ? b3c[c/8] : 1'b1;
      eb = (c < 80);
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL resend_3c c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c], cap_b[c],
                 es, eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fa;
    logic [9:0] fb;
    logic       es;
    logic       eb;
    fa = 10'b1000011110;
    fb = 10'b1111100000;
    @(negedge clk);
    p_data      = 8'h0F;
    parity_en   = 1'b0;
    parity_type = 1'b0;
    prescale    = 6'd2;
    data_valid  = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 42; c++) begin
      cap_s[c] = s_data;
      cap_b[c] = busy;
      if (c == 19) p_data = 8'hF0;
      if (c == 40) data_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 42; c++) begin
      if (c < 20) begin
        es = fa[c/2];
        eb = 1'b1;
      end else if (c >= 21 && c < 41) begin
        es = fb[(c-21)/2];
        eb = 1'b1;
      end else begin
        es = 1'b1;
        eb = 1'b0;
      end
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL b2b c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c], cap_b[c], es, eb);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    logic        es;
    logic        eb;
    bits = 11'b10010110100;
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    capture(20, -1);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (s_data !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_abort: s_data=%b busy=%b, expected 1 0", s_data, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    send(8'h5A, 1'b1, 1'b0, 6'd4);
    capture(46, -1);
    for (int c = 0; c < 46; c++) begin
      es = (c < 44) ? bits[c/4] : 1'b1;
      eb = (c < 44);
      n_vec++;
      if (cap_s[c] !== es || cap_b[c] !== eb) begin
        n_err++;
        $display("FAIL post_reset_5a c%0d: s_data=%b busy=%b, expected %b %b", c, cap_s[c],
                 cap_b[c], es, eb);
      end
    end
  endtask

  task automatic test_loopback();
    int         ps;
    logic [7:0] d;
    logic [7:0] rx;
    logic       pt;
    logic       rx_par;
    logic       rx_stop;
    logic       found;
    for (int k = 0; k < 3; k++) begin
      ps = 8 << k;
      for (int pe = 0; pe < 2; pe++) begin
        for (int w = 0; w < 8; w++) begin
          d  = 8'($urandom);
          pt = 1'($urandom_range(0, 1));
          send(d, pe[0], pt, 6'(ps));
          found = 1'b0;
          for (int t = 0; t < 4 && !found; t++) begin
            if (s_data === 1'b0) found = 1'b1;
            else @(negedge clk);
          end
          n_vec++;
          if (!found) begin
            n_err++;
            $display("FAIL lb_start ps%0d: no start bit, expected s_data 0 within 4 cycles", ps);
            repeat (12 * ps) @(negedge clk);
          end else begin
            repeat (ps / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
              repeat (ps) @(negedge clk);
              rx[b] = s_data;
            end
            rx_par = 1'b0;
            if (pe == 1) begin
              repeat (ps) @(negedge clk);
              rx_par = s_data;
            end
            repeat (ps) @(negedge clk);
            rx_stop = s_data;
            repeat (ps - ps / 2) @(negedge clk);
            n_vec++;
            if (rx !== d) begin
              n_err++;
              $display("FAIL lb_data ps%0d pe%0d: got %h, expected %h", ps, pe, rx, d);
            end
            if (pe == 1) begin
              n_vec++;
              if (rx_par !== (^rx ^ pt)) begin
                n_err++;
                $display("FAIL lb_parity ps%0d pt%0d: got %b, expected %b", ps, pt, rx_par,
                         ^rx ^ pt);
              end
            end
            n_vec++;
            if (rx_stop !== 1'b1 || s_data !== 1'b1 || busy !== 1'b0) begin
              n_err++;
              $display("FAIL lb_stop ps%0d: stop=%b idle=%b busy=%b, expected 1 1 0", ps, rx_stop,
                       s_data, busy);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_a5();
    test_parity_01();
    test_no_parity_ff();
    test_prescale_zero();
    test_ignore_mid_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits.
REQ-002 Parameter PWIDTH, default 6, width of the prescale input.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset; asserted (0) forces the reset state immediately, regardless of clk.
REQ-005 p_data  input  DWIDTH  parallel word to transmit; sampled only when the word is accepted.
REQ-006 data_valid  input  1  request to transmit p_data; honoured only in IDLE.
REQ-007 parity_en  input  1  1 = append a parity bit; sampled when the word is accepted.
REQ-008 parity_type  input  1  0 = even parity, 1 = odd parity; sampled when the word is accepted.
REQ-009 prescale  input  PWIDTH  clk cycles per serial bit; sampled when the word is accepted.
REQ-010 s_data  output  1  serial line; idles high.
REQ-011 busy  output  1  high from the cycle after acceptance until the frame's final stop cycle, inclusive.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE with data_valid=1 at a rising edge, the block SHALL latch p_data, parity_en, parity_type and prescale, and enter START.
REQ-014 In IDLE s_data SHALL be 1 and busy SHALL be 0; data_valid in any other state SHALL be ignored, with no queuing.
REQ-015 Latency: s_data SHALL go to 0 (start bit) and busy to 1 in the first cycle after the acceptance edge.
REQ-016 Each serial bit SHALL be held for exactly P clk cycles, where P is the latched prescale; a latched value of 0 SHALL be treated as 1.
REQ-017 A bit-period counter SHALL count 0..P-1; the state or bit index SHALL advance only when the counter reaches P-1, and the counter then wraps to 0.
REQ-018 DATA SHALL send the DWIDTH latched bits LSB first; a bit index 0..DWIDTH-1 SHALL select the bit, and DATA exits after index DWIDTH-1 completes.
REQ-019 DATA SHALL exit to PARITY if the latched parity_en=1, else to STOP.
REQ-020 The PARITY bit SHALL be the XOR of the latched data (even), or its inverse (odd).
REQ-021 STOP SHALL drive s_data=1 for one bit period and then return to IDLE.
REQ-022 Frame length SHALL be (DWIDTH+2+parity_en)*P cycles.
REQ-023 The earliest next acceptance SHALL be at the first IDLE edge, leaving a minimum gap of one clk cycle of idle-high between frames.
REQ-024 Changes to inputs during a frame SHALL NOT alter the frame in flight.
REQ-025 s_data SHALL be driven from a register, so it is glitch-free with no combinational path from the inputs.

Reset
REQ-026 While rst=0: state=IDLE, s_data=1, busy=0, and all counters, the data latch and the latched configuration cleared to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with s_data returning to 1 asynchronously.
REQ-028 After rst deasserts, the block SHALL accept a new word at the first rising edge where data_valid=1.

Structure
REQ-029 The state encodings (IDLE..STOP) and the parity_type encoding SHALL live in the shared package uart_pkg, alongside the default DWIDTH/PWIDTH values used by the receiver.
REQ-030 The bit-period counter plus bit index SHALL be one sub-module, tx_baud_counter, which takes the latched prescale and an enable and outputs a bit_done strobe and bit_index.
REQ-031 Parity SHALL be computed inline; no further sub-modules.

Verification
REQ-032 Case: p_data=0xA5, prescale=8, parity_en=1, parity_type=0 -> s_data per 8-cycle bit is 0,1,0,1,0,0,1,0,1,0,1 (88 cycles); busy high for 88 cycles.
REQ-033 Case: p_data=0x01, parity_en=1, parity_type=1 -> parity bit 0; with parity_type=0 -> parity bit 1.
REQ-034 Case: parity_en=0, prescale=4, p_data=0xFF -> frame of 40 cycles: start 0, eight 1s, stop 1.
REQ-035 Case: data_valid pulsed with p_data=0x3C during DATA of a 0xA5 frame -> 0xA5 frame unchanged, 0x3C never sent; a second data_valid in IDLE sends 0x3C.
REQ-036 Case: rst=0 mid-DATA -> s_data=1 and busy=0 immediately; a new 0x5A frame after release is correct.
REQ-037 Case: loopback into uart_rx with equal prescale (8, 16, 32), parity on/off, 256 random words -> receiver p_data matches each word; data_valid fires once per frame with no parity or stop errors.
